// File: rtl/fp_addsub_param.sv
// Multi-cycle IEEE-754 add/subtract with runtime op select, RNE/RTZ rounding and valid/ready handshakes.
// Define FP_ADDSUB_FLAGS_EN to add the out_flags port {invalid,overflow,underflow,inexact}.
module fp_addsub_param #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic                 in_op,
    input  logic                 in_rtz,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_z
`ifdef FP_ADDSUB_FLAGS_EN
    ,
    output logic [3:0]           out_flags
`endif
);

    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 4;
    localparam int SW     = MAN_W + 5;
    localparam int EW     = EXP_W + 2;
    localparam int SH_MAX = MAN_W + 3;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAXF = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [EXP_W-1:0] EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [EXP_W-1:0] EXP_F1   = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [MAN_W-1:0] MAN_ONES = {MAN_W{1'b1}};
    localparam logic [MAN_W-1:0] MAN_ZERO = {MAN_W{1'b0}};
    localparam logic [EW-1:0]    E_ONE    = EW'(1);
    localparam logic [EW-1:0]    E_OVF    = {2'b00, EXP_ONES};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_PACK, S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d, b_q, b_d;
    logic               rtz_q, rtz_d;
    logic               spec_q, spec_d;
    logic               sgn_q, sgn_d;
    logic               sub_q, sub_d;
    logic [EW-1:0]      exp_q, exp_d;
    logic [MW-1:0]      big_q, big_d, sml_q, sml_d, man_q, man_d;
    logic [EXP_W-1:0]   shamt_q, shamt_d;
    logic [MAN_W:0]     rman_q, rman_d;
    logic [W-1:0]       z_q, z_d;
`ifdef FP_ADDSUB_FLAGS_EN
    logic               inex_q, inex_d;
    logic [3:0]         flg_q, flg_d;
`endif

    // Mantissa right shift with every bit pushed past the sticky position ORed into it.
    function automatic logic [MW-1:0] align_sticky(input logic [MW-1:0] m, input logic [EXP_W-1:0] sh);
        logic [MW-1:0] shifted;
        logic [MW-1:0] mask;
        int            n;
        n       = (int'(sh) > SH_MAX) ? SH_MAX : int'(sh);
        shifted = m >> n;
        mask    = ~({MW{1'b1}} << n);
        return {shifted[MW-1:1], shifted[0] | (|(m & mask))};
    endfunction

    function automatic logic rne_up(input logic [3:0] lgrs, input logic rtz);
        return !rtz && lgrs[2] && (lgrs[1] || lgrs[0] || lgrs[3]);
    endfunction

    // Overflow saturates to Inf under RNE and to the largest finite value under RTZ.
    function automatic logic [W-1:0] pack_z(input logic s, input logic [EW-1:0] e,
                                            input logic [MAN_W:0] m, input logic rtz);
        if (e >= E_OVF)
            return rtz ? {s, EXP_MAXF, MAN_ONES} : {s, EXP_ONES, MAN_ZERO};
        if (e == E_ONE && !m[MAN_W])
            return {s, EXP_ZERO, m[MAN_W-1:0]};
        return {s, e[EXP_W-1:0], m[MAN_W-1:0]};
    endfunction

    logic               sa, sb;
    logic [EXP_W-1:0]   ea_f, eb_f, ea_e, eb_e;
    logic [MAN_W-1:0]   fa, fb;
    logic [MAN_W:0]     ma, mb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
    logic               spec_nan, spec_hit;
    logic [W-1:0]       spec_z;
    logic [SW-1:0]      sum_w;
    logic [MAN_W+1:0]   rnd_w;
    logic               norm_shift;

    assign {sa, ea_f, fa} = a_q;
    assign {sb, eb_f, fb} = b_q;
    assign ea_e   = (ea_f == EXP_ZERO) ? EXP_F1 : ea_f;
    assign eb_e   = (eb_f == EXP_ZERO) ? EXP_F1 : eb_f;
    assign ma     = {|ea_f, fa};
    assign mb     = {|eb_f, fb};
    assign a_nan  = (ea_f == EXP_ONES) && (fa != MAN_ZERO);
    assign b_nan  = (eb_f == EXP_ONES) && (fb != MAN_ZERO);
    assign a_inf  = (ea_f == EXP_ONES) && (fa == MAN_ZERO);
    assign b_inf  = (eb_f == EXP_ONES) && (fb == MAN_ZERO);
    assign a_zero = (ea_f == EXP_ZERO) && (fa == MAN_ZERO);
    assign b_zero = (eb_f == EXP_ZERO) && (fb == MAN_ZERO);
    assign a_ge   = (a_q[W-2:0] >= b_q[W-2:0]);
    assign spec_nan = a_nan || b_nan || (a_inf && b_inf && (sa != sb));

    always_comb begin
        spec_hit = 1'b1;
        spec_z   = a_q;
        if (spec_nan)              spec_z = QNAN;
        else if (a_inf)            spec_z = a_q;
        else if (b_inf)            spec_z = b_q;
        else if (a_zero && b_zero) spec_z = {sa & sb, {(W-1){1'b0}}};
        else if (a_zero)           spec_z = b_q;
        else if (b_zero)           spec_z = a_q;
        else                       spec_hit = 1'b0;
    end

    assign sum_w = sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
    assign rnd_w = {1'b0, man_q[MW-1:3]} + {{(MAN_W+1){1'b0}}, rne_up(man_q[3:0], rtz_q)};
    assign norm_shift = !man_q[MW-1] && (exp_q > E_ONE) && (man_q != '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (in_valid) state_d = S_UNPACK;
            S_UNPACK: state_d = spec_hit ? S_PACK : S_ALIGN;
            S_ALIGN:  state_d = S_ADD;
            S_ADD:    state_d = S_NORM;
            S_NORM:   if (!norm_shift) state_d = S_ROUND;
            S_ROUND:  state_d = S_PACK;
            S_PACK:   state_d = S_OUT;
            S_OUT:    if (out_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        a_d = a_q;  b_d = b_q;  rtz_d = rtz_q;  spec_d = spec_q;
        sgn_d = sgn_q;  sub_d = sub_q;  exp_d = exp_q;
        big_d = big_q;  sml_d = sml_q;  man_d = man_q;
        shamt_d = shamt_q;  rman_d = rman_q;  z_d = z_q;
`ifdef FP_ADDSUB_FLAGS_EN
        inex_d = inex_q;
        flg_d  = flg_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d   = in_a;
                    b_d   = {in_b[W-1] ^ in_op, in_b[W-2:0]};
                    rtz_d = in_rtz;
                end
            end
            S_UNPACK: begin
                // Ordering by full magnitude keeps the subtraction non-negative.
                spec_d  = spec_hit;
                sgn_d   = a_ge ? sa : sb;
                sub_d   = sa ^ sb;
                exp_d   = {2'b00, a_ge ? ea_e : eb_e};
                big_d   = {a_ge ? ma : mb, 3'b000};
                sml_d   = {a_ge ? mb : ma, 3'b000};
                shamt_d = a_ge ? (ea_e - eb_e) : (eb_e - ea_e);
                if (spec_hit) begin
                    z_d = spec_z;
`ifdef FP_ADDSUB_FLAGS_EN
                    flg_d = {spec_nan, 3'b000};
`endif
                end
            end
            S_ALIGN: sml_d = align_sticky(sml_q, shamt_q);
            S_ADD: begin
                if (sum_w[SW-1]) begin
                    man_d = {sum_w[SW-1:2], |sum_w[1:0]};
                    exp_d = exp_q + E_ONE;
                end else begin
                    man_d = sum_w[MW-1:0];
                end
                if (sum_w == '0) begin
                    sgn_d = 1'b0;
                    exp_d = E_ONE;
                end
            end
            S_NORM: begin
                if (norm_shift) begin
                    man_d = man_q << 1;
                    exp_d = exp_q - E_ONE;
                end
            end
            S_ROUND: begin
                if (rnd_w[MAN_W+1]) begin
                    rman_d = rnd_w[MAN_W+1:1];
                    exp_d  = exp_q + E_ONE;
                end else begin
                    rman_d = rnd_w[MAN_W:0];
                end
`ifdef FP_ADDSUB_FLAGS_EN
                inex_d = |man_q[2:0];
`endif
            end
            S_PACK: begin
                if (!spec_q) begin
                    z_d = pack_z(sgn_q, exp_q, rman_q, rtz_q);
`ifdef FP_ADDSUB_FLAGS_EN
                    flg_d = {1'b0, exp_q >= E_OVF,
                             (exp_q == E_ONE) && !rman_q[MAN_W] && inex_q,
                             inex_q || (exp_q >= E_OVF)};
`endif
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            z_q     <= '0;
`ifdef FP_ADDSUB_FLAGS_EN
            flg_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            z_q     <= z_d;
`ifdef FP_ADDSUB_FLAGS_EN
            flg_q   <= flg_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        a_q     <= a_d;
        b_q     <= b_d;
        rtz_q   <= rtz_d;
        spec_q  <= spec_d;
        sgn_q   <= sgn_d;
        sub_q   <= sub_d;
        exp_q   <= exp_d;
        big_q   <= big_d;
        sml_q   <= sml_d;
        man_q   <= man_d;
        shamt_q <= shamt_d;
        rman_q  <= rman_d;
`ifdef FP_ADDSUB_FLAGS_EN
        inex_q  <= inex_d;
`endif
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign out_valid = (state_q == S_OUT);
    assign out_z     = z_q;
`ifdef FP_ADDSUB_FLAGS_EN
    assign out_flags = flg_q;
`endif

endmodule

// File: tb/tb_fp_addsub_param.sv
// Scoreboard bench for fp_addsub_param: single-precision vectors plus one half-precision instance.
module tb_fp_addsub_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0, in_op = 1'b0, in_rtz = 1'b0, out_ready = 1'b1;
    logic [31:0] in_a = '0, in_b = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_z;
    logic        h_valid = 1'b0, h_oready = 1'b1;
    logic [15:0] h_a = '0, h_b = '0;
    logic        h_ready, h_ovalid;
    logic [15:0] h_z;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]  flags, h_flags;
`endif

    always #5 clk = ~clk;

    fp_addsub_param #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_rtz(in_rtz),
        .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z)
`ifdef FP_ADDSUB_FLAGS_EN
        , .out_flags(flags)
`endif
    );

    fp_addsub_param #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready),
        .in_a(h_a), .in_b(h_b), .in_op(1'b0), .in_rtz(1'b0),
        .out_valid(h_ovalid), .out_ready(h_oready), .out_z(h_z)
`ifdef FP_ADDSUB_FLAGS_EN
        , .out_flags(h_flags)
`endif
    );

    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    // lat < 0 leaves latency unchecked; hold > 0 keeps out_ready low that many cycles.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic rtz, input logic [31:0] ez,
                          input logic [3:0] ef, input int elat, input int hold);
        exp_t e;
        int   lat;
        int   guard;
        @(negedge clk);
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check({tag, "_ready"}, in_ready, 1);
            return;
        end
        in_a = a; in_b = b; in_op = op; in_rtz = rtz; in_valid = 1'b1;
        out_ready = (hold == 0);
        sb.push_back('{z: ez, f: ef, lat: elat});
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_rdy_drop"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        if (!out_valid) begin
            check({tag, "_valid"}, out_valid, 1);
            out_ready = 1'b1;
            return;
        end
        if (e.lat >= 0) check({tag, "_lat"}, lat, e.lat);
        check({tag, "_z"}, out_z, e.z);
`ifdef FP_ADDSUB_FLAGS_EN
        check({tag, "_flags"}, flags, e.f);
`endif
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_z"}, out_z, e.z);
            check({tag, "_hold_rdy"}, in_ready, 0);
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_rdy"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   lat;
        bit   seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 32'h0);
`ifdef FP_ADDSUB_FLAGS_EN
        check("rst_flags", flags, 4'h0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rel_in_ready", in_ready, 1);
        check("rel_h_ready", h_ready, 1);

        run_op("add_1_2",     32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 4'h0,  6, 0);
        run_op("sub_eq",      32'h3F800000, 32'h3F800000, 1'b1, 1'b0, 32'h00000000, 4'h0,  6, 0);
        run_op("negz_sub",    32'h80000000, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 4'h0,  2, 0);
        run_op("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 1'b0, 32'h7FC00000, 4'h8,  2, 0);
        run_op("ovf_rne",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b0, 32'h7F800000, 4'h5,  6, 0);
        run_op("ovf_rtz",     32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 1'b1, 32'h7F7FFFFF, 4'h5,  6, 0);
        run_op("sub_add",     32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 4'h0,  6, 0);
        run_op("sub_res",     32'h00800000, 32'h80000001, 1'b0, 1'b0, 32'h007FFFFF, 4'h0, -1, 0);
        run_op("norm2",       32'h3F800000, 32'h3F400000, 1'b1, 1'b0, 32'h3E800000, 4'h0,  8, 0);
        run_op("neg_res",     32'h3F800000, 32'h40000000, 1'b1, 1'b0, 32'hBF800000, 4'h0,  7, 0);
        run_op("tie_even",    32'h3F800000, 32'h33800000, 1'b0, 1'b0, 32'h3F800000, 4'h1,  6, 0);
        run_op("tie_odd",     32'h3F800001, 32'h33800000, 1'b0, 1'b0, 32'h3F800002, 4'h1,  6, 0);
        run_op("gr_rne",      32'h3F800000, 32'h33C00000, 1'b0, 1'b0, 32'h3F800001, 4'h1,  6, 0);
        run_op("gr_rtz",      32'h3F800000, 32'h33C00000, 1'b0, 1'b1, 32'h3F800000, 4'h1,  6, 0);
        run_op("sticky_rne",  32'h3F800000, 32'h00000001, 1'b0, 1'b0, 32'h3F800000, 4'h1,  6, 0);
        run_op("tiny_sub_rtz",32'h3F800000, 32'h00000001, 1'b1, 1'b1, 32'h3F7FFFFF, 4'h1,  7, 0);
        run_op("tiny_sub_rne",32'h3F800000, 32'h00000001, 1'b1, 1'b0, 32'h3F800000, 4'h1,  7, 0);
        run_op("qnan_in",     32'h7FC00000, 32'h3F800000, 1'b0, 1'b0, 32'h7FC00000, 4'h8,  2, 0);
        run_op("snan_in",     32'h3F800000, 32'h7F800001, 1'b0, 1'b0, 32'h7FC00000, 4'h8,  2, 0);
        run_op("ninf",        32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 32'hFF800000, 4'h0,  2, 0);
        run_op("sub_ninf",    32'h3F800000, 32'hFF800000, 1'b1, 1'b0, 32'h7F800000, 4'h0,  2, 0);
        run_op("zero_sub",    32'h00000000, 32'h3F800000, 1'b1, 1'b0, 32'hBF800000, 4'h0,  2, 0);
        run_op("backpress",   32'h3F800000, 32'h40000000, 1'b0, 1'b0, 32'h40400000, 4'h0,  6, 10);

        // Reset while the operation sits in ADD: nothing may come out.
        @(negedge clk);
        in_a = 32'h3F800000; in_b = 32'h40000000; in_op = 1'b0; in_rtz = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("midrst_rdy_low", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_rdy", in_ready, 1);
        check("midrst_z", out_z, 32'h0);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_out", {31'b0, seen}, 32'h0);
        run_op("after_rst",   32'h40000000, 32'h3F800000, 1'b0, 1'b0, 32'h40400000, 4'h0,  6, 0);

        // Half precision instance.
        @(negedge clk);
        h_a = 16'h3C00; h_b = 16'h3C00; h_valid = 1'b1;
        sb.push_back('{z: 32'h00004000, f: 4'h0, lat: 6});
        @(posedge clk);
        #1 h_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!h_ovalid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check("half_valid", {31'b0, h_ovalid}, 32'h1);
        check("half_lat", lat, e.lat);
        check("half_z", {16'h0, h_z}, e.z);
`ifdef FP_ADDSUB_FLAGS_EN
        check("half_flags", h_flags, e.f);
`endif
        @(posedge clk);
        @(negedge clk);
        check("half_post_rdy", h_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
